mem_arbiter: RTL and testbench

Two-port arbiter that shares the single synchronous program/data memory between the LC-3 processor core and a host loader/debug port. Each requester issues one read or write at a time with a req/ack handshake. The arbiter serializes accesses round-robin, drives the memory bus, and returns read data on the winning port.

---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares one synchronous program/data memory between the LC-3 core
// (requester 0) and the host loader/debug port (requester 1). Each
// requester holds req until it sees a one-cycle ack. Accesses are
// serialized through IDLE -> ACCESS -> RESP. Ties go to the port that
// did not win last time.
//
// Ports:
//   clk, reset          single clock; asynchronous active-high reset
//   req0/we0/addr0/wdata0, ack0/rdata0
//                       processor request channel and its response
//   req1/we1/addr1/wdata1, ack1/rdata1
//                       host loader request channel and its response
//   busy                high whenever the arbiter is not in IDLE
//   mem_we, mem_address, mem_wdata, mem_rdata
//                       memory bus; mem_rdata is valid READ_LATENCY
//                       cycles after mem_address is first driven
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  busy,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  // A read finishes on the edge where the counter reaches this value,
  // so ACCESS lasts exactly READ_LATENCY cycles.
  localparam logic [2:0] LastCount = 3'(READ_LATENCY - 1);

  state_t                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  lastGrant_q, lastGrant_d;
  logic [2:0]            count_q, count_d;
  logic                  memWe_q, memWe_d;
  logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
  logic [DATA_WIDTH-1:0] memWdata_q, memWdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  winner;

  // State register. Reset is asynchronous so an in-flight access is
  // abandoned the moment reset rises, including an active write strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      count_q     <= '0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      count_q     <= count_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  // Next-state logic. The winner's request is copied onto the memory bus
  // at grant, so later changes on the requester inputs have no effect.
  // memWe_q doubles as the "this access is a write" flag during ACCESS.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    count_d     = count_q;
    memWe_d     = memWe_q;
    memAddr_d   = memAddr_q;
    memWdata_d  = memWdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    winner      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // A lone requester wins outright; on a tie the port that
          // lost last time gets the memory.
          winner      = (req0 && req1) ? ~lastGrant_q : req1;
          grant_d     = winner;
          lastGrant_d = winner;
          memWe_d     = winner ? we1 : we0;
          memAddr_d   = winner ? addr1 : addr0;
          memWdata_d  = winner ? wdata1 : wdata0;
          count_d     = '0;
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        if (memWe_q) begin
          memWe_d = 1'b0;
          state_d = RESP;
        end else if (count_q == LastCount) begin
          if (grant_q) begin
            rdata1_d = mem_rdata;
          end else begin
            rdata0_d = mem_rdata;
          end
          state_d = RESP;
        end else begin
          count_d = count_q + 3'd1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ack0        = (state_q == RESP) && !grant_q;
  assign ack1        = (state_q == RESP) && grant_q;
  assign busy        = (state_q != IDLE);
  assign mem_we      = memWe_q;
  assign mem_address = memAddr_q;
  assign mem_wdata   = memWdata_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. Drivers issue requests on both ports and push
// the expected response into per-port queues; a negedge monitor pops and
// compares whenever an ack appears. Expected read data comes from a
// reference memory image that the drivers update as they issue writes.
// Port 0 uses addresses 0x02xx and port 1 uses 0x01xx in the random phase,
// so the data a port reads back never depends on the grant order.
module tb_mem_arbiter;

  localparam int Lat = 3;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, busy, mem_we;
  logic [15:0] rdata0, rdata1, mem_address, mem_wdata, mem_rdata;

  int          vectors = 0;
  int          miscompares = 0;

  exp_t        expQ0[$];
  exp_t        expQ1[$];
  int          ackOrder[$];
  logic [15:0] expLast [2];
  longint      pendSince [2];
  longint      lastAckTime = 0;
  int          lastAckPort = -1;
  int          busyCycles = 0;
  int          weCycles = 0;
  logic        prevAck0 = 1'b0;
  logic        prevAck1 = 1'b0;

  logic [15:0] tbMem [0:65535];
  bit          written [0:65535];
  logic [15:0] refMem [0:65535];
  bit          refWritten [0:65535];
  logic [15:0] rdPipe [0:Lat-2];

  mem_arbiter #(
    .ADDR_WIDTH  (16),
    .DATA_WIDTH  (16),
    .READ_LATENCY(Lat)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .we0        (we0),
    .addr0      (addr0),
    .wdata0     (wdata0),
    .ack0       (ack0),
    .rdata0     (rdata0),
    .req1       (req1),
    .we1        (we1),
    .addr1      (addr1),
    .wdata1     (wdata1),
    .ack1       (ack1),
    .rdata1     (rdata1),
    .busy       (busy),
    .mem_we     (mem_we),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-on contents of the memory: a fixed pattern plus one known word.
  function automatic logic [15:0] initVal(input logic [15:0] a);
    return (a == 16'h0005) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  function automatic logic [15:0] memRead(input logic [15:0] a);
    return written[a] ? tbMem[a] : initVal(a);
  endfunction

  function automatic logic [15:0] refRead(input logic [15:0] a);
    return refWritten[a] ? refMem[a] : initVal(a);
  endfunction

  // Synchronous memory with Lat-1 output pipeline stages: the word for an
  // address driven from edge t0 is on mem_rdata at edge t0+Lat.
  always @(posedge clk) begin
    if (mem_we) begin
      tbMem[mem_address]   <= mem_wdata;
      written[mem_address] <= 1'b1;
    end
    rdPipe[0] <= memRead(mem_address);
    for (int i = 1; i < Lat - 1; i++) begin
      rdPipe[i] <= rdPipe[i-1];
    end
  end
  assign mem_rdata = rdPipe[Lat-2];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic setPort(input int p, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
    if (p == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  // Record what the port must see back and update the reference image.
  task automatic pushExp(input int p, input logic w, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e.we   = w;
    e.addr = a;
    if (w) begin
      refMem[a]     = d;
      refWritten[a] = 1'b1;
      e.data        = d;
    end else begin
      e.data = refRead(a);
    end
    if (p == 0) expQ0.push_back(e);
    else        expQ1.push_back(e);
  endtask

  // Issue one request on port p (called at a negedge) and hold it until ack.
  task automatic applyStimulus(input int p, input logic w, input logic [15:0] a, input logic [15:0] d);
    bit got;
    got = 1'b0;
    pushExp(p, w, a, d);
    pendSince[p] = longint'($time);
    setPort(p, 1'b1, w, a, d);
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? ack0 : ack1;
    end
    if (!got) checkOutput("ack timeout", 32'd0, 32'd1);
    pendSince[p] = -1;
    setPort(p, 1'b0, w, a, d);
  endtask

  task automatic ackCheck(input int p, input logic prevAck);
    exp_t e;
    int   q;
    bit   viol;
    logic [15:0] own, other;
    q     = 1 - p;
    own   = (p == 0) ? rdata0 : rdata1;
    other = (p == 0) ? rdata1 : rdata0;
    checkOutput("ack single pulse", {31'd0, prevAck}, 32'd0);
    if ((p == 0 && expQ0.size() == 0) || (p == 1 && expQ1.size() == 0)) begin
      checkOutput("unexpected ack", 32'd1, 32'd0);
      return;
    end
    e = (p == 0) ? expQ0.pop_front() : expQ1.pop_front();
    checkOutput("ack latency", busyCycles, e.we ? 32'd2 : 32'(Lat + 1));
    checkOutput("mem_we cycles", weCycles, e.we ? 32'd1 : 32'd0);
    if (e.we) begin
      checkOutput("memory content", {16'd0, memRead(e.addr)}, {16'd0, e.data});
      checkOutput("rdata kept on write", {16'd0, own}, {16'd0, expLast[p]});
    end else begin
      checkOutput("read data", {16'd0, own}, {16'd0, e.data});
      expLast[p] = e.data;
    end
    checkOutput("other rdata held", {16'd0, other}, {16'd0, expLast[q]});
    viol = (lastAckPort == p) && (pendSince[q] >= 0) && (pendSince[q] < lastAckTime);
    checkOutput("fairness", {31'd0, viol}, 32'd0);
    ackOrder.push_back(p);
    lastAckPort = p;
    lastAckTime = longint'($time);
  endtask

  // Monitor: samples on the falling edge, tracks how long the current
  // transaction has been busy and how many cycles it strobed mem_we.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        busyCycles = 0;
        weCycles   = 0;
        prevAck0   = 1'b0;
        prevAck1   = 1'b0;
      end else begin
        if (busy) busyCycles++;
        else begin
          busyCycles = 0;
          weCycles   = 0;
        end
        if (mem_we) weCycles++;
        if (ack0 && ack1) checkOutput("both acks high", 32'd1, 32'd0);
        if (ack0) ackCheck(0, prevAck0);
        if (ack1) ackCheck(1, prevAck1);
        prevAck0 = ack0;
        prevAck1 = ack1;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    expLast[0] = 16'h0000;
    expLast[1] = 16'h0000;
    pendSince[0] = -1;
    pendSince[1] = -1;
    reset = 1'b1;
    setPort(0, 1'b0, 1'b0, 16'h0, 16'h0);
    setPort(1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) @(negedge clk);

    // Reset values
    checkOutput("reset ack0", {31'd0, ack0}, 32'd0);
    checkOutput("reset ack1", {31'd0, ack1}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("reset mem_address", {16'd0, mem_address}, 32'd0);
    checkOutput("reset mem_wdata", {16'd0, mem_wdata}, 32'd0);
    checkOutput("reset rdata0", {16'd0, rdata0}, 32'd0);
    checkOutput("reset rdata1", {16'd0, rdata1}, 32'd0);
    reset = 1'b0;

    // Single write from port 0
    @(negedge clk);
    pushExp(0, 1'b1, 16'h3000, 16'h1234);
    pendSince[0] = longint'($time);
    setPort(0, 1'b1, 1'b1, 16'h3000, 16'h1234);
    @(negedge clk);
    checkOutput("write mem_we", {31'd0, mem_we}, 32'd1);
    checkOutput("write mem_address", {16'd0, mem_address}, 32'h3000);
    checkOutput("write mem_wdata", {16'd0, mem_wdata}, 32'h1234);
    checkOutput("write no early ack", {31'd0, ack0}, 32'd0);
    @(negedge clk);
    checkOutput("write ack0", {31'd0, ack0}, 32'd1);
    checkOutput("write mem_we off in ack", {31'd0, mem_we}, 32'd0);
    pendSince[0] = -1;
    setPort(0, 1'b0, 1'b0, 16'h3000, 16'h1234);
    @(negedge clk);
    checkOutput("write idle busy", {31'd0, busy}, 32'd0);

    // Single read from port 1 of the preloaded word
    applyStimulus(1, 1'b0, 16'h0005, 16'h0000);
    checkOutput("read rdata1", {16'd0, rdata1}, 32'hBEEF);
    checkOutput("read rdata0 unchanged", {16'd0, rdata0}, 32'd0);

    // Tie: both ports hold requests for two writes each
    ackOrder.delete();
    fork
      begin
        applyStimulus(0, 1'b1, 16'h0400, 16'hA0A0);
        applyStimulus(0, 1'b1, 16'h0401, 16'hA1A1);
      end
      begin
        applyStimulus(1, 1'b1, 16'h0410, 16'hB0B0);
        applyStimulus(1, 1'b1, 16'h0411, 16'hB1B1);
      end
    join
    checkOutput("tie grant count", ackOrder.size(), 32'd4);
    for (int i = 0; i < 4 && i < ackOrder.size(); i++) begin
      checkOutput("tie grant order", ackOrder[i], i % 2);
    end

    // Early drop and address change during ACCESS
    @(negedge clk);
    pushExp(0, 1'b0, 16'h0220, 16'h0000);
    pendSince[0] = longint'($time);
    setPort(0, 1'b1, 1'b0, 16'h0220, 16'h0000);
    @(negedge clk);
    setPort(0, 1'b0, 1'b1, 16'h0221, 16'hFFFF);
    checkOutput("drop mem_address", {16'd0, mem_address}, 32'h0220);
    checkOutput("drop busy", {31'd0, busy}, 32'd1);
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        got = ack0;
      end
      checkOutput("drop ack0 seen", {31'd0, got}, 32'd1);
    end
    pendSince[0] = -1;
    repeat (2) @(negedge clk);
    checkOutput("drop rdata0 held", {16'd0, rdata0}, {16'd0, 16'h0220 ^ 16'h5A5A});

    // Reset during a port 1 read
    setPort(1, 1'b1, 1'b0, 16'h0005, 16'h0000);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst ack1", {31'd0, ack1}, 32'd0);
    checkOutput("rst busy", {31'd0, busy}, 32'd0);
    checkOutput("rst rdata1", {16'd0, rdata1}, 32'd0);
    checkOutput("rst mem_address", {16'd0, mem_address}, 32'd0);
    expLast[0] = 16'h0000;
    expLast[1] = 16'h0000;
    lastAckPort = -1;
    setPort(1, 1'b0, 1'b0, 16'h0005, 16'h0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (Lat + 2) @(negedge clk);
    checkOutput("rst no ack1 after release", {31'd0, ack1}, 32'd0);
    applyStimulus(1, 1'b0, 16'h0005, 16'h0000);
    checkOutput("re-read rdata1", {16'd0, rdata1}, 32'hBEEF);

    // Randomized traffic on both ports
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          applyStimulus(0, 1'($urandom_range(0, 1)), {8'h02, 8'($urandom)}, 16'($urandom));
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          applyStimulus(1, 1'($urandom_range(0, 1)), {8'h01, 8'($urandom)}, 16'($urandom));
        end
      end
    join

    repeat (5) @(negedge clk);
    checkOutput("port0 queue drained", expQ0.size(), 32'd0);
    checkOutput("port1 queue drained", expQ1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
